// File: rtl/alien_pkg.sv
// ============================================================================
// alien_pkg : shared motion and march-state types for the alien formation
// Revision  : 1.0
// ============================================================================
`default_nettype none

package alien_pkg;

  // Motion encoding shared with the existing alien movers.
  typedef enum logic [1:0] {
    NO_MOTION = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2,
    DOWN      = 2'd3
  } motion_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MARCH_R = 3'd1,
    ST_MARCH_L = 3'd2,
    ST_DESCEND = 3'd3,
    ST_LANDED  = 3'd4
  } march_state_t;

  // Wide enough for DOWN_STEPS up to 15.
  localparam int DCNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/alien_step_timer.sv
// ============================================================================
// alien_step_timer : frame-tick counter producing one step event per interval
//                    (ALIEN_SPEEDUP_EN: interval shrinks with alive_count)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module alien_step_timer #(
  parameter int PERIOD_W    = 8,
  parameter int BASE_PERIOD = 32,
  parameter int MIN_PERIOD  = 2,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick,
  input  logic [CNT_W-1:0] alive_count,
  output logic             step_evt
);

  localparam int SUM_W = PERIOD_W + 1;

  logic [PERIOD_W-1:0] tcount;
  logic [PERIOD_W-1:0] interval;

`ifdef ALIEN_SPEEDUP_EN
  logic [SUM_W-1:0] period_sum;

  always_comb begin
    period_sum = SUM_W'(MIN_PERIOD) + SUM_W'(alive_count);
    if (period_sum > SUM_W'(BASE_PERIOD)) begin
      interval = PERIOD_W'(BASE_PERIOD);
    end else if (period_sum < SUM_W'(MIN_PERIOD)) begin
      interval = PERIOD_W'(MIN_PERIOD);
    end else begin
      interval = period_sum[PERIOD_W-1:0];
    end
  end
`else
  logic unused_alive;
  assign unused_alive = ^alive_count;
  assign interval     = PERIOD_W'(BASE_PERIOD);
`endif

  // '>=' lets a freshly shortened interval fire on the very next tick.
  assign step_evt = tick & enable & (tcount >= (interval - PERIOD_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcount <= '0;
    end else if (step_evt) begin
      tcount <= '0;
    end else if (tick && enable) begin
      tcount <= tcount + PERIOD_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alien_march_ctrl.sv
// ============================================================================
// alien_march_ctrl : right/down/left/down march sequencer with landing stop
//                    (optional ALIEN_SPEEDUP_EN handled in alien_step_timer)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module alien_march_ctrl
  import alien_pkg::*;
#(
  parameter int PERIOD_W    = 8,
  parameter int BASE_PERIOD = 32,
  parameter int MIN_PERIOD  = 2,
  parameter int DOWN_STEPS  = 1,
  parameter int CNT_W       = 6,
  parameter int ROW_W       = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick,
  input  logic             canLeft,
  input  logic             canRight,
  input  logic             canDown,
  input  logic [CNT_W-1:0] alive_count,
  output logic [1:0]       Motion,
  output logic             step,
  output logic             dir_right,
  output logic             landed,
  output logic [ROW_W-1:0] rows_descended
);

  localparam logic [ROW_W-1:0]  ROWS_MAX    = '1;
  localparam logic [DCNT_W-1:0] DCOUNT_LOAD = DCNT_W'(DOWN_STEPS - 1);

  logic              step_evt;
  march_state_t      state, state_nx;
  logic [DCNT_W-1:0] dcount, dcount_nx;
  logic              dir_nx;
  logic              landed_nx;
  motion_t           motion_nx;
  logic [ROW_W-1:0]  rows_nx;

  alien_step_timer #(
    .PERIOD_W    (PERIOD_W),
    .BASE_PERIOD (BASE_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .tick        (tick),
    .alive_count (alive_count),
    .step_evt    (step_evt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      dcount         <= '0;
      dir_right      <= 1'b1;
      landed         <= 1'b0;
      Motion         <= NO_MOTION;
      step           <= 1'b0;
      rows_descended <= '0;
    end else begin
      state          <= state_nx;
      dcount         <= dcount_nx;
      dir_right      <= dir_nx;
      landed         <= landed_nx;
      Motion         <= motion_nx;
      step           <= (motion_nx != NO_MOTION);
      rows_descended <= rows_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    dcount_nx = dcount;
    dir_nx    = dir_right;
    motion_nx = NO_MOTION;

    if (step_evt) begin
      case (state)
        ST_IDLE: begin
          if (canRight) begin
            motion_nx = RIGHT;
            state_nx  = ST_MARCH_R;
          end else if (canDown) begin
            motion_nx = DOWN;
            dir_nx    = 1'b0;
            state_nx  = ST_DESCEND;
          end else begin
            state_nx  = ST_LANDED;
          end
        end
        ST_MARCH_R: begin
          if (canRight) begin
            motion_nx = RIGHT;
          end else if (canDown) begin
            motion_nx = DOWN;
            dcount_nx = DCOUNT_LOAD;
            dir_nx    = 1'b0;
            state_nx  = ST_DESCEND;
          end else begin
            state_nx  = ST_LANDED;
          end
        end
        ST_MARCH_L: begin
          if (canLeft) begin
            motion_nx = LEFT;
          end else if (canDown) begin
            motion_nx = DOWN;
            dcount_nx = DCOUNT_LOAD;
            dir_nx    = 1'b1;
            state_nx  = ST_DESCEND;
          end else begin
            state_nx  = ST_LANDED;
          end
        end
        ST_DESCEND: begin
          if (dcount != '0) begin
            if (canDown) begin
              motion_nx = DOWN;
              dcount_nx = dcount - DCNT_W'(1);
            end else begin
              state_nx  = ST_LANDED;
            end
          end else if (dir_right && canRight) begin
            motion_nx = RIGHT;
            state_nx  = ST_MARCH_R;
          end else if (!dir_right && canLeft) begin
            motion_nx = LEFT;
            state_nx  = ST_MARCH_L;
          end else if (canDown) begin
            motion_nx = DOWN;
          end else begin
            state_nx  = ST_LANDED;
          end
        end
        default: begin
          state_nx = ST_LANDED;
        end
      endcase
    end

    landed_nx = (state_nx == ST_LANDED);

    rows_nx = rows_descended;
    if ((motion_nx == DOWN) && (rows_descended != ROWS_MAX)) begin
      rows_nx = rows_descended + ROW_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alien_march_ctrl.sv
// ============================================================================
// tb_alien_march_ctrl : directed literal checks plus randomized run against a
//                       move-by-move reference model of the march rules
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_alien_march_ctrl;

  localparam int PERIOD_W    = 8;
  localparam int BASE_PERIOD = 10;
  localparam int MIN_PERIOD  = 2;
  localparam int DOWN_STEPS  = 2;
  localparam int CNT_W       = 6;
  localparam int ROW_W       = 2;
  localparam int ROWS_MAX    = (1 << ROW_W) - 1;

  localparam logic [1:0] M_NONE  = 2'd0;
  localparam logic [1:0] M_LEFT  = 2'd1;
  localparam logic [1:0] M_RIGHT = 2'd2;
  localparam logic [1:0] M_DOWN  = 2'd3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             enable = 1'b0;
  logic             tick = 1'b0;
  logic             canLeft = 1'b1;
  logic             canRight = 1'b1;
  logic             canDown = 1'b1;
  logic [CNT_W-1:0] alive_count = '0;
  logic [1:0]       Motion;
  logic             step;
  logic             dir_right;
  logic             landed;
  logic [ROW_W-1:0] rows_descended;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;

  alien_march_ctrl #(
    .PERIOD_W    (PERIOD_W),
    .BASE_PERIOD (BASE_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD),
    .DOWN_STEPS  (DOWN_STEPS),
    .CNT_W       (CNT_W),
    .ROW_W       (ROW_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .tick           (tick),
    .canLeft        (canLeft),
    .canRight       (canRight),
    .canDown        (canDown),
    .alive_count    (alive_count),
    .Motion         (Motion),
    .step           (step),
    .dir_right      (dir_right),
    .landed         (landed),
    .rows_descended (rows_descended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model: decides each move from the rules ----------------
  function automatic int model_interval(input int alive);
    int v;
`ifdef ALIEN_SPEEDUP_EN
    v = MIN_PERIOD + alive;
    if (v > BASE_PERIOD) v = BASE_PERIOD;
`else
    v = BASE_PERIOD;
`endif
    return v;
  endfunction

  int         m_ticks;
  bit         m_started, m_marching, m_landed, m_right;
  int         m_owed;
  logic [1:0] exp_motion;
  bit         exp_step;
  int         exp_rows;
  bit         hor_ok, hor_turn;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ticks = 0; m_started = 0; m_marching = 0; m_landed = 0; m_right = 1;
      m_owed = 0; exp_motion = M_NONE; exp_step = 0; exp_rows = 0;
    end else begin
      exp_motion = M_NONE;
      if (tick && enable) begin
        if (m_ticks >= model_interval(int'(alive_count)) - 1) begin
          m_ticks = 0;
          if (!m_landed) begin
            hor_ok   = m_right ? canRight : canLeft;
            hor_turn = !m_started || m_marching || (m_owed == 0);
            if (hor_turn && hor_ok) begin
              exp_motion = m_right ? M_RIGHT : M_LEFT;
              m_marching = 1;
            end else if (canDown) begin
              exp_motion = M_DOWN;
              if (!m_started) begin
                m_right = 0; m_owed = 0;
              end else if (m_marching) begin
                m_owed = DOWN_STEPS - 1; m_right = !m_right; m_marching = 0;
              end else if (m_owed > 0) begin
                m_owed--;
              end
            end else begin
              m_landed = 1;
            end
            m_started = 1;
          end
        end else begin
          m_ticks++;
        end
      end
      exp_step = (exp_motion != M_NONE);
      if (exp_motion == M_DOWN && exp_rows < ROWS_MAX) exp_rows++;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("motion", Motion, exp_motion);
      chk("step", step, exp_step);
      chk("dir_right", dir_right, m_right);
      chk("landed", landed, m_landed);
      chk("rows_descended", rows_descended, exp_rows);
    end
  end

  // ---------------- stimulus helpers (inputs change at negedge + 1) ----------------
  task automatic do_reset();
    @(negedge clk); #1;
    tick = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_motion", Motion, M_NONE);
    chk("rst_step", step, 0);
    chk("rst_dir", dir_right, 1);
    chk("rst_landed", landed, 0);
    chk("rst_rows", rows_descended, 0);
    @(negedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic ticks_expect(input int n, input logic [1:0] req);
    for (int i = 0; i < n - 1; i++) begin
      pulse_tick();
      chk("lit_quiet", Motion, M_NONE);
    end
    pulse_tick();
    chk("lit_motion", Motion, req);
    chk("lit_step", step, 1);
    chk("model_motion", exp_motion, req);
  endtask

  initial begin
    do_reset();
    run_cmp = 1'b1;
    enable = 1'b1;
    alive_count = 6'd40;

    // First step after a full base interval heads right.
    ticks_expect(BASE_PERIOD, M_RIGHT);
    chk("lit_dir_r", dir_right, 1);
    @(negedge clk); #1;
    chk("lit_pulse_end", Motion, M_NONE);

    // Ticks during enable-low are dropped, not made up later.
    repeat (3) pulse_tick();
    enable = 1'b0;
    repeat (10) pulse_tick();
    chk("lit_gated", Motion, M_NONE);
    enable = 1'b1;
    ticks_expect(BASE_PERIOD - 3, M_RIGHT);

    // Right edge: two DOWNs then LEFT.
    canRight = 1'b0;
    ticks_expect(BASE_PERIOD, M_DOWN);
    chk("lit_rows1", rows_descended, 1);
    chk("lit_dir_l", dir_right, 0);
    ticks_expect(BASE_PERIOD, M_DOWN);
    chk("lit_rows2", rows_descended, 2);
    ticks_expect(BASE_PERIOD, M_LEFT);

    // Left edge blocked: repeated DOWNs saturate the row counter.
    canLeft = 1'b0;
    ticks_expect(BASE_PERIOD, M_DOWN);
    ticks_expect(BASE_PERIOD, M_DOWN);
    ticks_expect(BASE_PERIOD, M_DOWN);
    chk("lit_rows_sat", rows_descended, ROWS_MAX);
    chk("model_rows_sat", exp_rows, ROWS_MAX);

    // Landing: no motion, sticky landed.
    canDown = 1'b0;
    repeat (BASE_PERIOD) pulse_tick();
    chk("lit_land_motion", Motion, M_NONE);
    chk("lit_landed", landed, 1);
    chk("model_landed", m_landed, 1);
    canLeft = 1'b1; canRight = 1'b1; canDown = 1'b1;
    repeat (2 * BASE_PERIOD) pulse_tick();
    chk("lit_landed_hold", landed, 1);

    do_reset();
`ifdef ALIEN_SPEEDUP_EN
    alive_count = 6'd0;
    ticks_expect(MIN_PERIOD, M_RIGHT);
    alive_count = 6'd5;
    ticks_expect(7, M_RIGHT);
    alive_count = 6'd40;
    repeat (5) pulse_tick();
    alive_count = 6'd0;
    pulse_tick();
    chk("lit_shrink", Motion, M_RIGHT);
`else
    alive_count = 6'd0;
    ticks_expect(BASE_PERIOD, M_RIGHT);
`endif

    // Randomized episodes checked cycle by cycle against the model.
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        tick     = ($urandom_range(0, 2) == 0);
        enable   = ($urandom_range(0, 9) != 0);
        canRight = ($urandom_range(0, 6) != 0);
        canLeft  = ($urandom_range(0, 6) != 0);
        canDown  = ($urandom_range(0, 29) != 0);
        if ($urandom_range(0, 15) == 0) alive_count = CNT_W'($urandom_range(0, 63));
        @(negedge clk); #1;
      end
    end

    tick = 1'b0;
    @(negedge clk); #1;
    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alien_march_ctrl.md
# alien_march_ctrl

Parametrised march controller for the alien formation. It generates one registered movement command per step interval: right, down, left, down, and so on. The step interval is counted in frame ticks and, optionally, shortens as aliens are destroyed. It sits between the frame-tick generator and the formation position registers, and supports multi-row descents and a landed/stop condition.

## Interface
Parameters:
- PERIOD_W, 8: width of the step-interval counter and period values
- BASE_PERIOD, 32: ticks per step when speedup is off, and the upper bound when it is on (1..2^PERIOD_W-1)
- MIN_PERIOD, 2: lower bound on ticks per step (>=1, <=BASE_PERIOD)
- DOWN_STEPS, 1: consecutive DOWN commands per edge hit (1..15)
- CNT_W, 6: width of alive_count
- ROW_W, 5: width of rows_descended

Ports:
- clk, in, 1: system clock
- reset_n, in, 1: asynchronous active-low reset
- enable, in, 1: march allowed; low freezes the tick counter and state
- tick, in, 1: one-cycle frame strobe
- canLeft, in, 1: formation may step left
- canRight, in, 1: formation may step right
- canDown, in, 1: formation may step down
- alive_count, in, CNT_W: aliens remaining; used only with speedup
- Motion, out, 2: 0 NO_MOTION, 1 LEFT, 2 RIGHT, 3 DOWN; non-zero for exactly one cycle per step
- step, out, 1: pulse coincident with non-zero Motion
- dir_right, out, 1: current horizontal heading
- landed, out, 1: sticky; formation reached the bottom
- rows_descended, out, ROW_W: DOWN commands issued, saturating

## Operation
- States: IDLE, MARCH_R, MARCH_L, DESCEND, LANDED.
- Step event: `tick & enable & (tcount >= interval-1)`. On a step event, tcount←0. On `tick & enable` without a step, tcount+1.
- IDLE on step:
  - canRight → RIGHT, go to MARCH_R.
  - else canDown → DOWN, go to DESCEND with dir_right←0.
  - else go to LANDED.
- MARCH_R on step:
  - canRight → RIGHT.
  - else canDown → DOWN, load dcount←DOWN_STEPS-1, dir_right←0, go to DESCEND.
  - else go to LANDED.
- MARCH_L: mirror of MARCH_R (canLeft, LEFT, dir_right←1).
- DESCEND on step:
  - dcount≠0: canDown → DOWN and dcount−1; else go to LANDED.
  - dcount=0: go in the heading direction (LEFT/RIGHT, into MARCH_L/MARCH_R) if that direction is allowed.
  - If the heading direction is blocked, issue DOWN again (canDown) or go to LANDED.
- LANDED: Motion held at 0 and landed=1 until reset.
- rows_descended increments on every DOWN and saturates at 2^ROW_W−1.
- enable low: Motion forced to 0 in the same registered path; state, tcount and dcount hold.

## Timing
- Reset (async assert, sync release) values:
  - Motion=0, step=0, dir_right=1, landed=0, rows_descended=0
  - state=IDLE, tcount=0, dcount=0
- Latency: Motion and step are registered and valid the cycle after the qualifying tick edge, for one cycle only.
- Interval change mid-count: the `>=` compare means a newly shorter interval triggers a step on the next tick.
- Blocked flags (canLeft/canRight/canDown) are sampled only on the step cycle.
- tick arriving while enable is low is ignored; no count is made up later.
- landed rises in the cycle after the step event that found canDown=0; Motion stays 0 in that cycle.

## Configuration
- ALIEN_SPEEDUP_EN defined: interval = clamp(MIN_PERIOD + alive_count, MIN_PERIOD, BASE_PERIOD).
  - Compute in PERIOD_W+1 bits, then clamp.
- Not defined: interval = BASE_PERIOD; alive_count is unused.

## Structure
- Shared package alien_pkg holds:
  - motion_t (NO_MOTION/LEFT/RIGHT/DOWN, 2 bits), shared with the existing alien movers
  - march_state_t
- Sub-module alien_step_timer: tick counter, interval computation (including the macro branch), step-event output.
- The FSM lives in alien_march_ctrl.

## Test plan
- Reset and first step, BASE_PERIOD=4, canRight=1: reset_n low mid-run → all outputs at reset values. After release, 4 ticks → single RIGHT pulse after the 4th tick; step=1 for one cycle.
- Right edge, DOWN_STEPS=2: canRight→0 → DOWN, DOWN on consecutive intervals, then LEFT. dir_right=0, rows_descended=2.
- Landing: in DESCEND, canDown=0 at a step → no Motion, landed=1 next cycle. Further ticks give no motion until reset.
- enable gating: enable low for 10 ticks mid-interval → no motion, tcount unchanged. Remaining ticks after re-enable complete the interval.
- Speedup, ALIEN_SPEEDUP_EN, MIN_PERIOD=2, BASE_PERIOD=32:
  - alive_count=40 → 32 ticks per step.
  - alive_count=5 → 7 ticks per step.
  - alive_count=0 → 2 ticks per step.
  - Dropping from 40 to 0 with tcount=10 → step on the next tick.
- Saturation, ROW_W=2: 5 DOWN commands → rows_descended stays 3.
